// File: rtl/chess_play_ctrl_p_if.sv
// rtl/chess_play_ctrl_p_if.sv - cursor/keypad inputs and board/status outputs of chess_play_ctrl_p
interface chess_play_ctrl_p_if #(
   parameter int BOARD_N    = 8,
   parameter int COORD_W    = 4,
   parameter int HIST_DEPTH = 16
);
   localparam int HC_W = $clog2(HIST_DEPTH) + 1;

   logic [COORD_W-1:0]            cursor_x;
   logic [COORD_W-1:0]            cursor_y;
   logic                          is_pressed;
   logic [12*BOARD_N*BOARD_N-1:0] board_data;
   logic [1:0]                    state;
   logic [1:0]                    game_over;
   logic                          turn;
   logic [2:0]                    sound_code;
   logic                          play_sound;
   logic [15:0]                   move_count;
   logic [HC_W-1:0]               hist_count;

   modport master (
      output cursor_x, cursor_y, is_pressed,
      input  board_data, state, game_over, turn, sound_code, play_sound, move_count, hist_count
   );

   modport slave (
      input  cursor_x, cursor_y, is_pressed,
      output board_data, state, game_over, turn, sound_code, play_sound, move_count, hist_count
   );
endinterface

// File: rtl/chess_play_ctrl_p.sv
// rtl/chess_play_ctrl_p.sv - N x N board-game controller with select/move, promotion, history undo, resign and restart
module chess_play_ctrl_p #(
   parameter int                   BOARD_N    = 8,
   parameter int                   COORD_W    = 4,
   parameter int                   HIST_DEPTH = 16,
   parameter logic [3*BOARD_N-1:0] BACK_RANK  = 24'hB194E5
) (
   input  logic               clk,
   input  logic               rstn,
   chess_play_ctrl_p_if.slave bus
);
   localparam int CELLS = BOARD_N * BOARD_N;
   localparam int IDX_W = $clog2(CELLS);
   localparam int PTR_W = $clog2(HIST_DEPTH);
   localparam int HC_W  = PTR_W + 1;
   localparam logic [COORD_W-1:0] N_C  = COORD_W'(BOARD_N);
   localparam logic [HC_W-1:0]    HD_C = HC_W'(HIST_DEPTH);

   typedef enum logic [1:0] {ST_PLAY = 2'b01, ST_SETTLE = 2'b10} state_t;
   typedef logic [7:0] board_t [CELLS];
   typedef struct packed {
      logic               side;
      logic [COORD_W-1:0] sx, sy, dx, dy;
      logic [7:0]         moved, capt;
   } hist_t;

   function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      int i;
      i = int'(y) * BOARD_N + int'(x);
      return IDX_W'(i);
   endfunction

   function automatic board_t init_board();
      board_t b;
      for (int k = 0; k < CELLS; k++) b[k] = '0;
      for (int c = 0; c < BOARD_N; c++) begin
         b[c]                         = {5'b00010, BACK_RANK[3*c +: 3]};
         b[BOARD_N + c]               = 8'h16;
         b[(BOARD_N-2)*BOARD_N + c]   = 8'h1E;
         b[(BOARD_N-1)*BOARD_N + c]   = {5'b00011, BACK_RANK[3*c +: 3]};
      end
      return b;
   endfunction

   state_t             state_q, state_d;
   logic [1:0]         game_over_q, game_over_d;
   logic               turn_q, turn_d, play_sound_q, play_sound_d;
   logic               has_sel_q, has_sel_d, prev_pressed_q, prev_pressed_d, armed_q, armed_d;
   logic [2:0]         sound_code_q, sound_code_d;
   logic [15:0]        move_count_q, move_count_d;
   logic [HC_W-1:0]    hist_count_q, hist_count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, top_ptr;
   logic [COORD_W-1:0] sel_x_q, sel_x_d, sel_y_q, sel_y_d;
   board_t             board_q, board_d;
   hist_t              hist_mem [HIST_DEPTH];
   hist_t              top, push_e;
   logic               hist_we, press, own, promo;
   logic [IDX_W-1:0]   cur_idx, sel_idx, src_idx, dst_idx;
   logic [7:0]         cur, moved, landed;

   // armed_q blocks a key that was already held when reset released from firing.
   assign press   = bus.is_pressed & ~prev_pressed_q & armed_q;
   assign top_ptr = wr_ptr_q - PTR_W'(1);
   assign top     = hist_mem[top_ptr];
   assign src_idx = cell_idx(top.sx, top.sy);
   assign dst_idx = cell_idx(top.dx, top.dy);
   assign cur_idx = cell_idx(bus.cursor_x, bus.cursor_y);
   assign sel_idx = cell_idx(sel_x_q, sel_y_q);
   assign cur     = board_q[cur_idx];
   assign moved   = board_q[sel_idx];
   assign own     = cur[4] && (cur[3] == turn_q);
   assign promo   = (moved[2:0] == 3'd6) && (bus.cursor_y == (turn_q ? COORD_W'(0) : N_C - COORD_W'(1)));
   assign landed  = promo ? {moved[7:3], 3'd2} : moved;

   always_comb begin
      state_d        = state_q;
      game_over_d    = game_over_q;
      turn_d         = turn_q;
      sound_code_d   = sound_code_q;
      play_sound_d   = 1'b0;
      move_count_d   = move_count_q;
      hist_count_d   = hist_count_q;
      wr_ptr_d       = wr_ptr_q;
      has_sel_d      = has_sel_q;
      sel_x_d        = sel_x_q;
      sel_y_d        = sel_y_q;
      board_d        = board_q;
      prev_pressed_d = bus.is_pressed;
      armed_d        = armed_q | ~bus.is_pressed;
      hist_we        = 1'b0;
      push_e         = '{side: turn_q, sx: sel_x_q, sy: sel_y_q, dx: bus.cursor_x, dy: bus.cursor_y,
                         moved: moved, capt: cur};
      if (press) begin
         play_sound_d = 1'b1;
         sound_code_d = 3'd4;
         if (bus.cursor_x < N_C && bus.cursor_y < N_C) begin
            if (state_q == ST_PLAY) begin
               if (has_sel_q && bus.cursor_x == sel_x_q && bus.cursor_y == sel_y_q) begin
                  has_sel_d    = 1'b0;
                  play_sound_d = 1'b0;
                  sound_code_d = sound_code_q;
               end else if (own) begin
                  has_sel_d    = 1'b1;
                  sel_x_d      = bus.cursor_x;
                  sel_y_d      = bus.cursor_y;
                  sound_code_d = 3'd1;
               end else if (has_sel_q) begin
                  board_d[sel_idx] = '0;
                  board_d[cur_idx] = landed;
                  hist_we          = 1'b1;
                  wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                  if (hist_count_q != HD_C) hist_count_d = hist_count_q + HC_W'(1);
                  if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
                  turn_d    = ~turn_q;
                  has_sel_d = 1'b0;
                  if (cur[4] && cur[2:0] == 3'd1) begin
                     game_over_d  = turn_q ? 2'b01 : 2'b10;
                     state_d      = ST_SETTLE;
                     sound_code_d = 3'd5;
                  end else begin
                     sound_code_d = cur[4] ? 3'd3 : 3'd2;
                  end
               end
            end
         end else if (bus.cursor_y == N_C) begin
            case (bus.cursor_x)
               COORD_W'(0): if (hist_count_q != '0) begin
                  board_d[src_idx] = top.moved;
                  board_d[dst_idx] = top.capt;
                  turn_d           = top.side;
                  wr_ptr_d         = top_ptr;
                  hist_count_d     = hist_count_q - HC_W'(1);
                  move_count_d     = move_count_q - 16'd1;
                  has_sel_d        = 1'b0;
                  game_over_d      = 2'b00;
                  state_d          = ST_PLAY;
                  sound_code_d     = 3'd6;
               end
               COORD_W'(1): if (state_q == ST_PLAY) begin
                  game_over_d  = turn_q ? 2'b10 : 2'b01;
                  state_d      = ST_SETTLE;
                  has_sel_d    = 1'b0;
                  sound_code_d = 3'd5;
               end
               COORD_W'(2): begin
                  board_d      = init_board();
                  hist_count_d = '0;
                  wr_ptr_d     = '0;
                  move_count_d = '0;
                  game_over_d  = 2'b00;
                  has_sel_d    = 1'b0;
                  sel_x_d      = '0;
                  sel_y_d      = '0;
                  turn_d       = 1'b0;
                  state_d      = ST_PLAY;
                  sound_code_d = 3'd7;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= ST_PLAY;
         game_over_q    <= 2'b00;
         turn_q         <= 1'b0;
         sound_code_q   <= 3'd0;
         play_sound_q   <= 1'b0;
         move_count_q   <= '0;
         hist_count_q   <= '0;
         wr_ptr_q       <= '0;
         has_sel_q      <= 1'b0;
         sel_x_q        <= '0;
         sel_y_q        <= '0;
         prev_pressed_q <= 1'b0;
         armed_q        <= 1'b0;
         board_q        <= init_board();
      end else begin
         state_q        <= state_d;
         game_over_q    <= game_over_d;
         turn_q         <= turn_d;
         sound_code_q   <= sound_code_d;
         play_sound_q   <= play_sound_d;
         move_count_q   <= move_count_d;
         hist_count_q   <= hist_count_d;
         wr_ptr_q       <= wr_ptr_d;
         has_sel_q      <= has_sel_d;
         sel_x_q        <= sel_x_d;
         sel_y_q        <= sel_y_d;
         prev_pressed_q <= prev_pressed_d;
         armed_q        <= armed_d;
         board_q        <= board_d;
      end
   end

   always_ff @(posedge clk) begin
      if (hist_we) hist_mem[wr_ptr_q] <= push_e;
   end

   assign bus.state      = state_q;
   assign bus.game_over  = game_over_q;
   assign bus.turn       = turn_q;
   assign bus.sound_code = sound_code_q;
   assign bus.play_sound = play_sound_q;
   assign bus.move_count = move_count_q;
   assign bus.hist_count = hist_count_q;

   always_comb begin
      bus.board_data = '0;
      for (int k = 0; k < CELLS; k++) begin
         bus.board_data[12*k +: 12] = {1'b0,
            (hist_count_q != '0) && (IDX_W'(k) == src_idx || IDX_W'(k) == dst_idx),
            has_sel_q, has_sel_q && (IDX_W'(k) == sel_idx), board_q[k]};
      end
   end
endmodule

// File: tb/tb_chess_play_ctrl_p.sv
// tb/tb_chess_play_ctrl_p.sv - randomized self-checking bench for chess_play_ctrl_p against a board-level model
`timescale 1ns/1ps
module tb_chess_play_ctrl_p;
   localparam int N  = 8;
   localparam int CW = 4;
   localparam int HD = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   chess_play_ctrl_p_if #(.BOARD_N(N), .COORD_W(CW), .HIST_DEPTH(HD)) bus ();
   chess_play_ctrl_p #(.BOARD_N(N), .COORD_W(CW), .HIST_DEPTH(HD), .BACK_RANK(24'hB194E5)) dut (
      .clk(clk), .rstn(rstn), .bus(bus));

   typedef struct {
      int         side, sx, sy, dx, dy;
      logic [7:0] moved, capt;
   } mv_t;

   logic [7:0] mb [N][N];
   mv_t        hist [$];
   int m_turn, m_settle, m_go, m_sel, m_sx, m_sy, m_mc, m_snd, m_pcyc;
   bit m_pv;
   int cyc = 0;
   int n_assert = 0, n_fail = 0;
   bit chk_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset_board();
      int br [8] = '{5, 4, 3, 2, 1, 3, 4, 5};
      for (int y = 0; y < N; y++) for (int x = 0; x < N; x++) mb[y][x] = 8'h00;
      for (int x = 0; x < N; x++) begin
         mb[0][x]   = 8'(8'h10 + br[x]);
         mb[1][x]   = 8'h16;
         mb[N-2][x] = 8'h1E;
         mb[N-1][x] = 8'(8'h18 + br[x]);
      end
   endtask

   task automatic model_reset();
      model_reset_board();
      hist.delete();
      m_turn = 0; m_settle = 0; m_go = 0; m_sel = 0; m_sx = 0; m_sy = 0;
      m_mc = 0; m_snd = 0; m_pv = 0;
   endtask

   task automatic model_press(input int x, input int y);
      int code;
      logic [7:0] c, p;
      mv_t e;
      code = 4;
      if (x < N && y < N) begin
         c = mb[y][x];
         if (m_settle != 0) code = 4;
         else if (m_sel != 0 && x == m_sx && y == m_sy) begin m_sel = 0; code = 0; end
         else if (c[4] && int'(c[3]) == m_turn) begin m_sel = 1; m_sx = x; m_sy = y; code = 1; end
         else if (m_sel != 0) begin
            p = mb[m_sy][m_sx];
            e.side = m_turn; e.sx = m_sx; e.sy = m_sy; e.dx = x; e.dy = y; e.moved = p; e.capt = c;
            hist.push_back(e);
            if (hist.size() > HD) void'(hist.pop_front());
            mb[m_sy][m_sx] = 8'h00;
            if (p[2:0] == 3'd6 && y == (m_turn != 0 ? 0 : N - 1)) p[2:0] = 3'd2;
            mb[y][x] = p;
            if (m_mc < 65535) m_mc++;
            m_sel = 0;
            if (c[4] && c[2:0] == 3'd1) begin m_settle = 1; m_go = (m_turn == 0) ? 2 : 1; code = 5; end
            else code = c[4] ? 3 : 2;
            m_turn = 1 - m_turn;
         end
      end else if (y == N && x == 0) begin
         if (hist.size() > 0) begin
            e = hist.pop_back();
            mb[e.sy][e.sx] = e.moved;
            mb[e.dy][e.dx] = e.capt;
            m_turn = e.side; m_mc--; m_sel = 0; m_settle = 0; m_go = 0; code = 6;
         end
      end else if (y == N && x == 1) begin
         if (m_settle == 0) begin m_go = (m_turn != 0) ? 2 : 1; m_settle = 1; m_sel = 0; code = 5; end
      end else if (y == N && x == 2) begin
         model_reset_board();
         hist.delete();
         m_mc = 0; m_go = 0; m_settle = 0; m_sel = 0; m_sx = 0; m_sy = 0; m_turn = 0; code = 7;
      end
      if (code != 0) begin m_snd = code; m_pv = 1; m_pcyc = cyc; end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         int bad, bk;
         logic [11:0] ec, ac, fe, fa;
         bit hl;
         mv_t t;
         chk("state", bus.state, m_settle != 0 ? 2 : 1);
         chk("game_over", bus.game_over, m_go);
         chk("turn", bus.turn, m_turn);
         chk("sound_code", bus.sound_code, m_snd);
         chk("play_sound", bus.play_sound, (m_pv && cyc == m_pcyc) ? 1 : 0);
         chk("move_count", bus.move_count, m_mc);
         chk("hist_count", bus.hist_count, hist.size());
         bad = 0; bk = 0; fe = '0; fa = '0;
         for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
               hl = 0;
               if (hist.size() > 0) begin
                  t  = hist[hist.size() - 1];
                  hl = (x == t.sx && y == t.sy) || (x == t.dx && y == t.dy);
               end
               ec = {1'b0, hl, m_sel != 0, m_sel != 0 && x == m_sx && y == m_sy, mb[y][x]};
               ac = bus.board_data[12*(y*N+x) +: 12];
               if (ac != ec) begin
                  if (bad == 0) begin bk = y*N+x; fe = ec; fa = ac; end
                  bad++;
               end
            end
         end
         n_assert++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL board_data: %0d cells differ, first cell %0d got %03h expected %03h (t=%0t)",
                     bad, bk, fa, fe, $time);
         end
      end
   end

   function automatic logic [11:0] dcell(input int x, input int y);
      return bus.board_data[12*(y*N+x) +: 12];
   endfunction

   task automatic do_press(input int x, input int y);
      @(negedge clk);
      bus.cursor_x   = CW'(x);
      bus.cursor_y   = CW'(y);
      bus.is_pressed = 1'b1;
      @(posedge clk);
      #1 model_press(x, y);
      @(negedge clk);
      bus.is_pressed = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, r, px, py;
      int ox [$], oy [$];
      bus.cursor_x = '0; bus.cursor_y = '0; bus.is_pressed = 1'b0;
      model_reset();
      chk_en = 1;
      repeat (3) @(negedge clk);
      #1 rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_state", bus.state, 2'b01);
      chk("reset_king", dcell(4, 0), 12'h011);
      chk("reset_bqueen", dcell(3, 7), 12'h01A);
      chk("reset_brook", dcell(0, 7), 12'h01D);

      do_press(4, 1); do_press(4, 3);
      chk("t1_dst", dcell(4, 3), 12'h416);
      chk("t1_src", dcell(4, 1), 12'h400);
      chk("t1_turn", bus.turn, 1);
      chk("t1_sound", bus.sound_code, 2);
      chk("t1_pulse", bus.play_sound, 1);
      chk("t1_mc", bus.move_count, 1);
      do_press(2, N);

      do_press(0, 1); do_press(0, 7);
      chk("t2_promo", dcell(0, 7) & 12'h0FF, 8'h12);
      chk("t2_sound", bus.sound_code, 3);
      do_press(0, N);
      chk("t2_src", dcell(0, 1) & 12'h0FF, 8'h16);
      chk("t2_dst", dcell(0, 7) & 12'h0FF, 8'h1D);
      chk("t2_turn", bus.turn, 0);
      chk("t2_sound_undo", bus.sound_code, 6);

      do_press(0, 1); do_press(4, 7);
      chk("t3_state", bus.state, 2'b10);
      chk("t3_go", bus.game_over, 2'b10);
      chk("t3_sound", bus.sound_code, 5);
      do_press(3, 3);
      chk("t3_denied", bus.sound_code, 4);
      do_press(0, N);
      chk("t3_state_undo", bus.state, 2'b01);
      chk("t3_go_undo", bus.game_over, 2'b00);

      do_press(2, N);
      for (int i = 0; i < 3; i++) begin
         do_press(i, 1); do_press(i, 2);
         do_press(i, 6); do_press(i, 5);
      end
      chk("t4_hist", bus.hist_count, 4);
      for (int i = 0; i < 4; i++) begin
         do_press(0, N);
         chk("t4_undo_sound", bus.sound_code, 6);
      end
      do_press(0, N);
      chk("t4_empty_undo", bus.sound_code, 4);
      chk("t4_cell_a", dcell(0, 2) & 12'h0FF, 8'h16);
      chk("t4_cell_b", dcell(0, 5) & 12'h0FF, 8'h1E);
      chk("t4_cell_c", dcell(1, 1) & 12'h0FF, 8'h16);
      chk("t4_mc", bus.move_count, 2);

      do_press(2, N);
      do_press(3, 1); do_press(3, 2);
      do_press(1, N);
      chk("t5_go", bus.game_over, 2'b10);
      chk("t5_state", bus.state, 2'b10);
      do_press(2, N);
      chk("t5_mc", bus.move_count, 0);
      chk("t5_hist", bus.hist_count, 0);
      chk("t5_sound", bus.sound_code, 7);
      chk("t5_cell", dcell(3, 1), 12'h016);

      pulses = 0;
      @(negedge clk);
      bus.cursor_x = CW'(4); bus.cursor_y = CW'(1); bus.is_pressed = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 if (i == 0) model_press(4, 1);
         @(negedge clk);
         if (bus.play_sound) pulses++;
      end
      chk("t6_hold_pulses", pulses, 1);
      #1 rstn = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 rstn = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.play_sound) pulses++;
      end
      chk("t6_reset_hold", pulses, 0);
      bus.is_pressed = 1'b0;
      repeat (2) @(negedge clk);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin px = 0; py = N; end
         else if (r < 10) begin px = 1; py = N; end
         else if (r < 11) begin px = 2; py = N; end
         else if (r < 13) begin px = $urandom_range(3, 15); py = N; end
         else if (r < 14) begin px = $urandom_range(0, 15); py = $urandom_range(N + 1, 15); end
         else if (r < 15) begin px = $urandom_range(N, 15); py = $urandom_range(0, N - 1); end
         else if (r < 55) begin
            ox.delete(); oy.delete();
            for (int y = 0; y < N; y++)
               for (int x = 0; x < N; x++)
                  if (mb[y][x][4] && int'(mb[y][x][3]) == m_turn) begin ox.push_back(x); oy.push_back(y); end
            if (ox.size() > 0) begin
               r = $urandom_range(0, ox.size() - 1);
               px = ox[r]; py = oy[r];
            end else begin px = $urandom_range(0, N - 1); py = $urandom_range(0, N - 1); end
         end else begin px = $urandom_range(0, N - 1); py = $urandom_range(0, N - 1); end
         do_press(px, py);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
